mcpu_ctrl: RTL and testbench
============================

Name: mcpu_ctrl

Overview:
Multicycle control FSM for the MCPU datapath. It sits directly upstream of the ALU and supplies its 4-bit ALUOp and the rt operand-select code. It consumes the ALU Zero flag to resolve branches. It also drives every datapath mux/enable: PC, IR, memory, register file and ALU source selection, and handshakes with a variable-latency memory.

Parameters:
RESET_PC_SEL, 0, PCSource value driven while idle/reset (kept 0 = ALU result)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
funct  in  6  IR[5:0]
mem_ready  in  1  memory access complete this cycle
Zero  in  1  ALU zero flag
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if Zero
IorD  out  1  0=PC, 1=ALUOut as memory address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR
MemtoReg  out  1  1=MDR to regfile
RegDst  out  1  1=rd, 0=rt
RegWrite  out  1  regfile write enable
ExtOp  out  1  1=sign-extend imm, 0=zero-extend
ALUSrcA  out  2  0=PC, 1=rs, 2=shamt zero-extended
ALUSrcB  out  2  0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2
ALUOp  out  4  operation code, encodings from alu_define.v macros
PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
illegal  out  1  sticky: unsupported opcode/funct decoded

Behaviour:
- State register only is sequential. Outputs are Moore decode of state plus opcode/funct, except the mem_ready gating listed below. On rst_n low: state=FETCH, illegal=0, immediately and asynchronously.
- Default for every output not listed in a state: 0. ALUOp default `ADD.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=`ADD, PCSource=0. IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; on mem_ready=1 go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUOp=`ADD (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXEC_R
  - 100011/101011 (LW/SW) -> ADDR
  - 000100/000101/000111/000110/000001 (BEQ/BNE/BGTZ/BLEZ/BLTZ-BGEZ) -> BRANCH
  - 000010 -> JUMP
  - 001000/001100/001101/001110/001111 (ADDI/ANDI/ORI/XORI/LUI) -> EXEC_I
  - else set illegal=1 and go to FETCH.
- EXEC_R: ALUSrcB=0. funct 100000/100010/100100/100101/100110/100111/101010/101011 -> `ADD/`SUB/`AND/`OR/`XOR/`NOR/`SLT/`SLTU, ALUSrcA=1. funct 000000/000010/000011 -> `SLL/`SRL/`SRA, ALUSrcA=2. Unknown funct: illegal=1, next FETCH, no writeback. Otherwise next ALU_WB with RegDst=1.
- EXEC_I: ALUSrcA=1, ALUSrcB=2. ADDI -> `ADD with ExtOp=1. ANDI/ORI/XORI -> `AND/`OR/`XOR with ExtOp=0. LUI -> `LU. Next ALU_WB with RegDst=0.
- ALU_WB: RegWrite=1, MemtoReg=0, RegDst per originating class (R=1, I=0). Next FETCH.
- ADDR: ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUOp=`ADD. Next MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEM_WR: MemWrite=1, IorD=1. Hold until mem_ready, then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, PCSource=1, PCWriteCond=1. ALUOp: BEQ `SUB, BNE `BNE, BGTZ `BGTZ, BLEZ `BLEZ, 000001 `BLTZ (ALU uses rt[0]). Taken always means Zero=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=2. Next FETCH.
- Instruction latency (cycles, zero-wait memory): R/I 4, LW 5, SW 4, branch 3, J 3. Each mem_ready=0 cycle adds one.
- illegal is sticky until reset. Fetch continues after an illegal instruction (treated as NOP).
- Reset asserted mid-instruction: no partial RegWrite/MemWrite after the edge; FETCH restarts.
- Undefined state encodings -> FETCH.

Test Plan:
- Reset mid-MEM_WR (rst_n low 1 cycle) -> MemWrite=0 immediately; after release state FETCH, MemRead=1, IorD=0.
- ADD (opcode 0, funct 100000), mem_ready=1 -> FETCH, DECODE, EXEC_R (ALUOp=`ADD, ALUSrcA=1), ALU_WB (RegWrite=1, RegDst=1); 4 cycles total.
- LW with mem_ready low 2 cycles in FETCH and 3 in MEM_RD -> IRWrite pulses once, only on the mem_ready cycle; RegWrite+MemtoReg in cycle 10.
- BNE then BGTZ with Zero=1 and Zero=0 -> ALUOp=`BNE/`BGTZ, PCWriteCond=1, PCSource=1 in BRANCH. Taken-ness is left to Zero.
- SRA (funct 000011) -> ALUSrcA=2, ALUOp=`SRA. ORI -> ExtOp=0, ALUOp=`OR, RegDst=0.
- opcode 111111 -> illegal=1 after DECODE, next state FETCH, no RegWrite/MemWrite; illegal stays 1 across following instructions.

Source files
------------

// File: rtl/mcpu_ctrl.sv
// ============================================================================
//  Module   : mcpu_ctrl
//  Brief    : Multicycle control FSM for the MCPU datapath. Drives PC, IR,
//             memory, register-file and ALU-source selects, supplies ALUOp,
//             and handshakes with a variable-latency memory via mem_ready.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_ctrl #(
    parameter logic [1:0] RESET_PC_SEL = 2'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ExtOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal
);

    // ALU operation codes (must match the ALU's decode table)
    localparam logic [3:0] C_ALU_ADD  = 4'd0;
    localparam logic [3:0] C_ALU_SUB  = 4'd1;
    localparam logic [3:0] C_ALU_AND  = 4'd2;
    localparam logic [3:0] C_ALU_OR   = 4'd3;
    localparam logic [3:0] C_ALU_XOR  = 4'd4;
    localparam logic [3:0] C_ALU_NOR  = 4'd5;
    localparam logic [3:0] C_ALU_SLT  = 4'd6;
    localparam logic [3:0] C_ALU_SLTU = 4'd7;
    localparam logic [3:0] C_ALU_SLL  = 4'd8;
    localparam logic [3:0] C_ALU_SRL  = 4'd9;
    localparam logic [3:0] C_ALU_SRA  = 4'd10;
    localparam logic [3:0] C_ALU_LU   = 4'd11;
    localparam logic [3:0] C_ALU_BNE  = 4'd12;
    localparam logic [3:0] C_ALU_BGTZ = 4'd13;
    localparam logic [3:0] C_ALU_BLEZ = 4'd14;
    localparam logic [3:0] C_ALU_BLTZ = 4'd15;

    // Opcodes
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_REGIM = 6'b000001;
    localparam logic [5:0] C_OP_J     = 6'b000010;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_BNE   = 6'b000101;
    localparam logic [5:0] C_OP_BLEZ  = 6'b000110;
    localparam logic [5:0] C_OP_BGTZ  = 6'b000111;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_ANDI  = 6'b001100;
    localparam logic [5:0] C_OP_ORI   = 6'b001101;
    localparam logic [5:0] C_OP_XORI  = 6'b001110;
    localparam logic [5:0] C_OP_LUI   = 6'b001111;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;

    // FSM states
    localparam logic [3:0] C_ST_FETCH  = 4'd0;
    localparam logic [3:0] C_ST_DECODE = 4'd1;
    localparam logic [3:0] C_ST_EXEC_R = 4'd2;
    localparam logic [3:0] C_ST_EXEC_I = 4'd3;
    localparam logic [3:0] C_ST_ALU_WB = 4'd4;
    localparam logic [3:0] C_ST_ADDR   = 4'd5;
    localparam logic [3:0] C_ST_MEM_RD = 4'd6;
    localparam logic [3:0] C_ST_MEM_WB = 4'd7;
    localparam logic [3:0] C_ST_MEM_WR = 4'd8;
    localparam logic [3:0] C_ST_BRANCH = 4'd9;
    localparam logic [3:0] C_ST_JUMP   = 4'd10;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       r_illegal;
    logic       w_set_illegal;
    logic       w_funct_ok;
    logic [3:0] w_r_aluop;
    logic [1:0] w_r_srca;

    // Branch resolution happens in the datapath (PCWriteCond & Zero)
    logic w_unused_zero;
    assign w_unused_zero = Zero;

    // R-type funct decode shared by next-state and output logic
    always_comb begin
        w_funct_ok = 1'b1;
        w_r_aluop  = C_ALU_ADD;
        w_r_srca   = 2'd1;
        case (funct)
            6'b100000: w_r_aluop = C_ALU_ADD;
            6'b100010: w_r_aluop = C_ALU_SUB;
            6'b100100: w_r_aluop = C_ALU_AND;
            6'b100101: w_r_aluop = C_ALU_OR;
            6'b100110: w_r_aluop = C_ALU_XOR;
            6'b100111: w_r_aluop = C_ALU_NOR;
            6'b101010: w_r_aluop = C_ALU_SLT;
            6'b101011: w_r_aluop = C_ALU_SLTU;
            6'b000000: begin w_r_aluop = C_ALU_SLL; w_r_srca = 2'd2; end
            6'b000010: begin w_r_aluop = C_ALU_SRL; w_r_srca = 2'd2; end
            6'b000011: begin w_r_aluop = C_ALU_SRA; w_r_srca = 2'd2; end
            default:   w_funct_ok = 1'b0;
        endcase
    end

    // State register: reset forces FETCH asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= C_ST_FETCH;
        else        r_state <= w_next_state;
    end

    // Sticky illegal-instruction flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_illegal <= 1'b0;
        else if (w_set_illegal) r_illegal <= 1'b1;
    end

    // Next-state logic
    always_comb begin
        w_next_state  = C_ST_FETCH;
        w_set_illegal = 1'b0;
        case (r_state)
            C_ST_FETCH:  w_next_state = mem_ready ? C_ST_DECODE : C_ST_FETCH;
            C_ST_DECODE: begin
                case (opcode)
                    C_OP_RTYPE:                 w_next_state = C_ST_EXEC_R;
                    C_OP_LW, C_OP_SW:           w_next_state = C_ST_ADDR;
                    C_OP_BEQ, C_OP_BNE, C_OP_BGTZ,
                    C_OP_BLEZ, C_OP_REGIM:      w_next_state = C_ST_BRANCH;
                    C_OP_J:                     w_next_state = C_ST_JUMP;
                    C_OP_ADDI, C_OP_ANDI, C_OP_ORI,
                    C_OP_XORI, C_OP_LUI:        w_next_state = C_ST_EXEC_I;
                    default: begin
                        w_next_state  = C_ST_FETCH;
                        w_set_illegal = 1'b1;
                    end
                endcase
            end
            C_ST_EXEC_R: begin
                if (w_funct_ok) begin
                    w_next_state = C_ST_ALU_WB;
                end else begin
                    w_next_state  = C_ST_FETCH;
                    w_set_illegal = 1'b1;
                end
            end
            C_ST_EXEC_I: w_next_state = C_ST_ALU_WB;
            C_ST_ALU_WB: w_next_state = C_ST_FETCH;
            C_ST_ADDR:   w_next_state = (opcode == C_OP_LW) ? C_ST_MEM_RD : C_ST_MEM_WR;
            C_ST_MEM_RD: w_next_state = mem_ready ? C_ST_MEM_WB : C_ST_MEM_RD;
            C_ST_MEM_WB: w_next_state = C_ST_FETCH;
            C_ST_MEM_WR: w_next_state = mem_ready ? C_ST_FETCH : C_ST_MEM_WR;
            C_ST_BRANCH: w_next_state = C_ST_FETCH;
            C_ST_JUMP:   w_next_state = C_ST_FETCH;
            default:     w_next_state = C_ST_FETCH;
        endcase
    end

    // Output decode: Moore on state + IR fields, FETCH gated by mem_ready
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ExtOp       = 1'b0;
        ALUSrcA     = 2'd0;
        ALUSrcB     = 2'd0;
        ALUOp       = C_ALU_ADD;
        PCSource    = RESET_PC_SEL;
        case (r_state)
            C_ST_FETCH: begin
                MemRead  = 1'b1;
                ALUSrcB  = 2'd1;
                PCSource = 2'd0;
                IRWrite  = mem_ready;
                PCWrite  = mem_ready;
            end
            C_ST_DECODE: begin
                ALUSrcB = 2'd3;
                ExtOp   = 1'b1;
            end
            C_ST_EXEC_R: begin
                ALUSrcA = w_r_srca;
                ALUOp   = w_r_aluop;
                RegDst  = 1'b1;
            end
            C_ST_EXEC_I: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                case (opcode)
                    C_OP_ADDI: begin ALUOp = C_ALU_ADD; ExtOp = 1'b1; end
                    C_OP_ANDI: ALUOp = C_ALU_AND;
                    C_OP_ORI:  ALUOp = C_ALU_OR;
                    C_OP_XORI: ALUOp = C_ALU_XOR;
                    C_OP_LUI:  ALUOp = C_ALU_LU;
                    default:   ALUOp = C_ALU_ADD;
                endcase
            end
            C_ST_ALU_WB: begin
                RegWrite = 1'b1;
                // IR still holds the instruction, so its class picks rd vs rt
                RegDst   = (opcode == C_OP_RTYPE);
            end
            C_ST_ADDR: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                ExtOp   = 1'b1;
            end
            C_ST_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            C_ST_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            C_ST_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            C_ST_BRANCH: begin
                ALUSrcA     = 2'd1;
                PCSource    = 2'd1;
                PCWriteCond = 1'b1;
                case (opcode)
                    C_OP_BEQ:   ALUOp = C_ALU_SUB;
                    C_OP_BNE:   ALUOp = C_ALU_BNE;
                    C_OP_BGTZ:  ALUOp = C_ALU_BGTZ;
                    C_OP_BLEZ:  ALUOp = C_ALU_BLEZ;
                    C_OP_REGIM: ALUOp = C_ALU_BLTZ;
                    default:    ALUOp = C_ALU_SUB;
                endcase
            end
            C_ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'd2;
            end
            default: ;
        endcase
    end

    assign illegal = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_mcpu_ctrl.sv
// ============================================================================
//  Module   : tb_mcpu_ctrl
//  Brief    : Directed self-checking bench for mcpu_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcpu_ctrl;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_OR   = 4'd3;
    localparam logic [3:0] C_SRA  = 4'd10;
    localparam logic [3:0] C_BNE  = 4'd12;
    localparam logic [3:0] C_BGTZ = 4'd13;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       Zero;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ExtOp, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, PCSource;
    logic [3:0] ALUOp;

    int checks = 0;
    int errors = 0;

    mcpu_ctrl #(.RESET_PC_SEL(2'd0)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .Zero(Zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ExtOp(ExtOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return at the following negedge plus settle time
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0; Zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (MemRead !== 1'b1 || IorD !== 1'b0 || ALUSrcB !== 2'd1) begin
            errors++;
            $display("FAIL reset_fetch: MemRead=%b IorD=%b ALUSrcB=%0d, want 1 0 1", MemRead, IorD, ALUSrcB);
        end
        checks++;
        if (illegal !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: illegal=%b RegWrite=%b MemWrite=%b PCWrite=%b IRWrite=%b, want all 0",
                     illegal, RegWrite, MemWrite, PCWrite, IRWrite);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        opcode = 6'b000000; funct = 6'b100000; mem_ready = 1'b1;
        #1;
        checks++;
        if (MemRead !== 1'b1 || IRWrite !== 1'b1 || PCWrite !== 1'b1 || PCSource !== 2'd0) begin
            errors++;
            $display("FAIL add_fetch: MemRead=%b IRWrite=%b PCWrite=%b PCSource=%0d, want 1 1 1 0", MemRead, IRWrite, PCWrite, PCSource);
        end
        next_cycle();
        checks++;
        if (ALUSrcB !== 2'd3 || ExtOp !== 1'b1 || ALUSrcA !== 2'd0 || MemRead !== 1'b0) begin
            errors++;
            $display("FAIL add_decode: ALUSrcB=%0d ExtOp=%b ALUSrcA=%0d MemRead=%b, want 3 1 0 0", ALUSrcB, ExtOp, ALUSrcA, MemRead);
        end
        next_cycle();
        checks++;
        if (ALUOp !== C_ADD || ALUSrcA !== 2'd1 || ALUSrcB !== 2'd0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL add_exec: ALUOp=%0d ALUSrcA=%0d ALUSrcB=%0d RegWrite=%b, want 0 1 0 0", ALUOp, ALUSrcA, ALUSrcB, RegWrite);
        end
        next_cycle();
        checks++;
        if (RegWrite !== 1'b1 || RegDst !== 1'b1 || MemtoReg !== 1'b0) begin
            errors++;
            $display("FAIL add_wb: RegWrite=%b RegDst=%b MemtoReg=%b, want 1 1 0", RegWrite, RegDst, MemtoReg);
        end
        next_cycle();
        checks++;
        if (MemRead !== 1'b1 || IorD !== 1'b0 || RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL add_refetch: MemRead=%b IorD=%b RegWrite=%b, want 1 0 0", MemRead, IorD, RegWrite);
        end
    endtask

    // LW: mem_ready low in cycles 1,2 (FETCH) and 6,7,8 (MEM_RD)
    task automatic test_lw_wait();
        int ir_pulses;
        logic [10:1] ready_sched;
        ir_pulses   = 0;
        ready_sched = 10'b1100011100;   // bit n = mem_ready in cycle n
        opcode = 6'b100011; funct = 6'd0;
        for (int c = 1; c <= 10; c++) begin
            mem_ready = ready_sched[c];
            #1;
            if (IRWrite === 1'b1) ir_pulses++;
            checks++;
            if (IRWrite !== (c == 3)) begin
                errors++;
                $display("FAIL lw_irwrite_c%0d: IRWrite=%b, want %b", c, IRWrite, (c == 3));
            end
            if (c >= 6 && c <= 9) begin
                checks++;
                if (MemRead !== 1'b1 || IorD !== 1'b1 || RegWrite !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_memrd_c%0d: MemRead=%b IorD=%b RegWrite=%b, want 1 1 0", c, MemRead, IorD, RegWrite);
                end
            end
            if (c == 10) begin
                checks++;
                if (RegWrite !== 1'b1 || MemtoReg !== 1'b1 || RegDst !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_wb: RegWrite=%b MemtoReg=%b RegDst=%b, want 1 1 0", RegWrite, MemtoReg, RegDst);
                end
            end
            if (c < 10) next_cycle();
        end
        checks++;
        if (ir_pulses != 1) begin
            errors++;
            $display("FAIL lw_ir_pulses: got %0d, want 1", ir_pulses);
        end
        mem_ready = 1'b1;
        next_cycle();
        checks++;
        if (MemRead !== 1'b1 || IorD !== 1'b0) begin
            errors++;
            $display("FAIL lw_refetch: MemRead=%b IorD=%b, want 1 0", MemRead, IorD);
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [2];
        logic [3:0] exp [2];
        logic       zs  [2];
        ops[0] = 6'b000101; exp[0] = C_BNE;  zs[0] = 1'b1;
        ops[1] = 6'b000111; exp[1] = C_BGTZ; zs[1] = 1'b0;
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            opcode = ops[i]; Zero = zs[i];
            next_cycle();   // DECODE
            next_cycle();   // BRANCH
            checks++;
            if (ALUOp !== exp[i] || PCWriteCond !== 1'b1 || PCSource !== 2'd1 || ALUSrcA !== 2'd1 || ALUSrcB !== 2'd0 || PCWrite !== 1'b0) begin
                errors++;
                $display("FAIL branch_%0d: ALUOp=%0d PCWriteCond=%b PCSource=%0d ALUSrcA=%0d ALUSrcB=%0d PCWrite=%b, want %0d 1 1 1 0 0",
                         i, ALUOp, PCWriteCond, PCSource, ALUSrcA, ALUSrcB, PCWrite, exp[i]);
            end
            next_cycle();   // FETCH
            checks++;
            if (MemRead !== 1'b1 || PCWriteCond !== 1'b0) begin
                errors++;
                $display("FAIL branch_refetch_%0d: MemRead=%b PCWriteCond=%b, want 1 0", i, MemRead, PCWriteCond);
            end
        end
        Zero = 1'b0;
    endtask

    task automatic test_sra_ori();
        mem_ready = 1'b1;
        opcode = 6'b000000; funct = 6'b000011;
        next_cycle(); next_cycle();
        checks++;
        if (ALUSrcA !== 2'd2 || ALUOp !== C_SRA) begin
            errors++;
            $display("FAIL sra_exec: ALUSrcA=%0d ALUOp=%0d, want 2 %0d", ALUSrcA, ALUOp, C_SRA);
        end
        next_cycle(); next_cycle();   // ALU_WB -> FETCH
        opcode = 6'b001101; funct = 6'd0;
        next_cycle(); next_cycle();
        checks++;
        if (ExtOp !== 1'b0 || ALUOp !== C_OR || ALUSrcA !== 2'd1 || ALUSrcB !== 2'd2) begin
            errors++;
            $display("FAIL ori_exec: ExtOp=%b ALUOp=%0d ALUSrcA=%0d ALUSrcB=%0d, want 0 %0d 1 2", ExtOp, ALUOp, ALUSrcA, ALUSrcB, C_OR);
        end
        next_cycle();
        checks++;
        if (RegWrite !== 1'b1 || RegDst !== 1'b0 || MemtoReg !== 1'b0) begin
            errors++;
            $display("FAIL ori_wb: RegWrite=%b RegDst=%b MemtoReg=%b, want 1 0 0", RegWrite, RegDst, MemtoReg);
        end
        next_cycle();
    endtask

    task automatic test_bad_funct();
        mem_ready = 1'b1;
        opcode = 6'b000000; funct = 6'b111111;
        next_cycle(); next_cycle();   // EXEC_R
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL badfunct_pre: illegal=%b, want 0", illegal);
        end
        next_cycle();
        checks++;
        if (illegal !== 1'b1 || RegWrite !== 1'b0 || MemRead !== 1'b1 || IorD !== 1'b0) begin
            errors++;
            $display("FAIL badfunct_post: illegal=%b RegWrite=%b MemRead=%b IorD=%b, want 1 0 1 0", illegal, RegWrite, MemRead, IorD);
        end
    endtask

    task automatic test_reset_mid_memwr();
        mem_ready = 1'b1; opcode = 6'b101011; funct = 6'd0;
        next_cycle();                 // DECODE
        next_cycle();                 // ADDR
        mem_ready = 1'b0;
        next_cycle();                 // MEM_WR, stalled
        checks++;
        if (MemWrite !== 1'b1 || IorD !== 1'b1) begin
            errors++;
            $display("FAIL sw_memwr: MemWrite=%b IorD=%b, want 1 1", MemWrite, IorD);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || RegWrite !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: MemWrite=%b RegWrite=%b illegal=%b, want 0 0 0", MemWrite, RegWrite, illegal);
        end
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks++;
        if (MemRead !== 1'b1 || IorD !== 1'b0 || MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: MemRead=%b IorD=%b MemWrite=%b, want 1 0 0", MemRead, IorD, MemWrite);
        end
    endtask

    task automatic test_illegal_opcode();
        mem_ready = 1'b1; opcode = 6'b111111;
        next_cycle();                 // DECODE
        checks++;
        if (illegal !== 1'b0 || ALUSrcB !== 2'd3) begin
            errors++;
            $display("FAIL illop_decode: illegal=%b ALUSrcB=%0d, want 0 3", illegal, ALUSrcB);
        end
        next_cycle();
        checks++;
        if (illegal !== 1'b1 || MemRead !== 1'b1 || IorD !== 1'b0 || RegWrite !== 1'b0 || MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL illop_after: illegal=%b MemRead=%b IorD=%b RegWrite=%b MemWrite=%b, want 1 1 0 0 0",
                     illegal, MemRead, IorD, RegWrite, MemWrite);
        end
        // A following legal ADD still executes and illegal stays set
        opcode = 6'b000000; funct = 6'b100000;
        next_cycle(); next_cycle(); next_cycle();
        checks++;
        if (illegal !== 1'b1 || RegWrite !== 1'b1 || RegDst !== 1'b1) begin
            errors++;
            $display("FAIL illop_sticky: illegal=%b RegWrite=%b RegDst=%b, want 1 1 1", illegal, RegWrite, RegDst);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_sra_ori();
        test_bad_funct();
        test_reset_mid_memwr();
        test_illegal_opcode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule

`default_nettype wire
